// File: rtl/sd_spi_responder.sv
// sd_spi_responder
//   SPI-mode SD card responder. Decodes 6-byte SD commands received over a
//   mode-0 SPI link and answers with R1, and for CMD17 a single data block
//   (token 0xFE, BLOCK_LEN bytes fetched from a backing store, two 0xFF CRC bytes).
//   All logic runs on iCLK; the SPI pins are oversampled through 2-FF synchronizers.
//
// Ports
//   iCLK     in   system clock (at least 4x SD_CLK)
//   Reset    in   asynchronous active-low reset
//   SD_CLK   in   SPI clock from the initiator
//   SD_MOSI  in   SPI data from the initiator
//   SD_CS    in   SPI chip select, active-low
//   SD_MISO  out  SPI data to the initiator (1 while deselected)
//   oRdAddr  out  backing-store byte address (CMD17 argument + byte index)
//   iRdData  in   backing-store byte, valid one iCLK after oRdAddr changes
//   oIdle    out  card idle flag (R1 bit 0)
//   oBusy    out  high whenever the responder is not waiting for a command
module sd_spi_responder #(
    parameter int NCR       = 1,
    parameter int NAC       = 2,
    parameter int BLOCK_LEN = 512
) (
    input  logic        iCLK,
    input  logic        Reset,
    input  logic        SD_CLK,
    input  logic        SD_MOSI,
    input  logic        SD_CS,
    output logic        SD_MISO,
    output logic [31:0] oRdAddr,
    input  logic [7:0]  iRdData,
    output logic        oIdle,
    output logic        oBusy
);

    typedef enum logic [2:0] {
        S_WAITCMD, S_CMD, S_NCR, S_R1, S_NAC, S_TOKEN, S_DATA, S_CRC
    } state_t;

    // [0],[1] form the synchronizer, [2] holds the previous synchronized value
    logic [2:0]  sclk_q, cs_q;
    logic [1:0]  mosi_q;

    state_t      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        pend_q, pend_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  idx_q, idx_d;
    logic        idle_q, idle_d;
    logic [31:0] addr_q, addr_d;

    logic        cs_rise, cs_fall, sclk_rise, sclk_fall, rx_done;
    logic [7:0]  rx_byte, tx_load;
    logic        r1_illegal;

    // Deselected SPI clock edges are ignored, including one coincident with CS rising
    assign cs_rise   =  cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] &  cs_q[2];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2] & ~cs_q[1];
    assign rx_done   = sclk_rise & (bit_q == 3'd7);
    assign rx_byte   = {rx_q, mosi_q[1]};

    always_comb begin
        r1_illegal = 1'b1;
        case (cmd_q)
            6'd0, 6'd1, 6'd16, 6'd17, 6'd41: r1_illegal = 1'b0;
            default:                         r1_illegal = 1'b1;
        endcase
    end

    // idle_q already reflects the command when S_R1 is active, so R1 is a pure decode
    always_comb begin
        tx_load = 8'hFF;
        case (state_q)
            S_R1:    tx_load = {5'b0, r1_illegal, 1'b0, idle_q};
            S_TOKEN: tx_load = 8'hFE;
            S_DATA:  tx_load = iRdData;
            default: tx_load = 8'hFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        pend_d  = pend_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        addr_d  = addr_q;

        if (cs_q[1]) begin
            bit_d = 3'd0;
        end else if (sclk_rise) begin
            bit_d = bit_q + 3'd1;
            rx_d  = rx_byte[6:0];
        end

        // The byte loaded after a completed byte is chosen by the state the FSM moved to.
        // Data-phase loads advance the address a whole byte ahead of the next load.
        if (cs_fall) begin
            tx_d   = 8'hFF;
            pend_d = 1'b0;
        end else if (sclk_fall) begin
            if (pend_q) begin
                tx_d   = tx_load;
                pend_d = 1'b0;
                if (state_q == S_DATA) begin
                    idx_d = idx_q + 10'd1;
                    if (idx_q != 10'(BLOCK_LEN - 1)) addr_d = addr_q + 32'd1;
                end
            end else begin
                tx_d = {tx_q[6:0], 1'b1};
            end
        end
        if (rx_done) pend_d = 1'b1;

        if (cs_rise) begin
            state_d = S_WAITCMD;
            cnt_d   = 8'd0;
            pend_d  = 1'b0;
        end else if (rx_done) begin
            case (state_q)
                S_WAITCMD: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        cmd_d   = rx_byte[5:0];
                        cnt_d   = 8'd0;
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q < 8'd4) arg_d = {arg_q[23:0], rx_byte};
                    if (cnt_q == 8'd4) begin
                        cnt_d   = 8'd0;
                        state_d = (NCR == 0) ? S_R1 : S_NCR;
                        if (cmd_q == 6'd17) addr_d = arg_q;
                    end
                end
                S_NCR: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(NCR - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = S_R1;
                    end
                end
                S_R1: begin
                    cnt_d = 8'd0;
                    if (cmd_q == 6'd17 && !idle_q) state_d = (NAC == 0) ? S_TOKEN : S_NAC;
                    else                           state_d = S_WAITCMD;
                end
                S_NAC: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(NAC - 1)) begin
                        cnt_d   = 8'd0;
                        state_d = S_TOKEN;
                    end
                end
                S_TOKEN: begin
                    idx_d   = 10'd0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    cnt_d = 8'd0;
                    if (idx_q == 10'(BLOCK_LEN)) state_d = S_CRC;
                end
                S_CRC: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = S_WAITCMD;
                    end
                end
                default: state_d = S_WAITCMD;
            endcase
        end

        // Idle flag changes as R1 is selected, so R1 reports the post-command value
        if (state_d == S_R1 && state_q != S_R1) begin
            if (cmd_q == 6'd0)                       idle_d = 1'b1;
            else if (cmd_q == 6'd1 || cmd_q == 6'd41) idle_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge Reset) begin
        if (!Reset) begin
            sclk_q  <= 3'b000;
            cs_q    <= 3'b111;
            mosi_q  <= 2'b11;
            state_q <= S_WAITCMD;
            bit_q   <= 3'd0;
            rx_q    <= 7'd0;
            tx_q    <= 8'hFF;
            pend_q  <= 1'b0;
            cmd_q   <= 6'd0;
            arg_q   <= 32'd0;
            cnt_q   <= 8'd0;
            idx_q   <= 10'd0;
            idle_q  <= 1'b1;
            addr_q  <= 32'd0;
        end else begin
            sclk_q  <= {sclk_q[1:0], SD_CLK};
            cs_q    <= {cs_q[1:0], SD_CS};
            mosi_q  <= {mosi_q[0], SD_MOSI};
            state_q <= state_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            pend_q  <= pend_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            addr_q  <= addr_d;
        end
    end

    assign SD_MISO = cs_q[1] ? 1'b1 : tx_q[7];
    assign oRdAddr = addr_q;
    assign oIdle   = idle_q;
    assign oBusy   = (state_q != S_WAITCMD);

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder
//   Directed bench for sd_spi_responder: drives SPI mode-0 frames at SD_CLK = iCLK/8
//   and checks responses, flags and backing-store addressing.
module tb_sd_spi_responder;

    logic        iCLK    = 1'b0;
    logic        Reset   = 1'b0;
    logic        SD_CLK  = 1'b0;
    logic        SD_MOSI = 1'b1;
    logic        SD_CS   = 1'b1;
    logic        SD_MISO;
    logic [31:0] oRdAddr;
    logic [7:0]  iRdData;
    logic        oIdle;
    logic        oBusy;

    int errs   = 0;
    int checks = 0;

    sd_spi_responder #(.NCR(1), .NAC(2), .BLOCK_LEN(512)) dut (
        .iCLK    (iCLK),
        .Reset   (Reset),
        .SD_CLK  (SD_CLK),
        .SD_MOSI (SD_MOSI),
        .SD_CS   (SD_CS),
        .SD_MISO (SD_MISO),
        .oRdAddr (oRdAddr),
        .iRdData (iRdData),
        .oIdle   (oIdle),
        .oBusy   (oBusy)
    );

    always #5 iCLK = ~iCLK;

    // Backing store contents as a function of address; read latency of one iCLK
    function automatic logic [7:0] store_f(input logic [31:0] a);
        return a[7:0] ^ {a[9:8], a[11:10], a[9:8], a[11:10]} ^ 8'hA5;
    endfunction

    always @(posedge iCLK) iRdData <= store_f(oRdAddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tb_byte, output logic [7:0] rb);
        for (int i = 7; i >= 0; i--) begin
            SD_MOSI = tb_byte[i];
            #40;
            rb[i]  = SD_MISO;
            SD_CLK = 1'b1;
            #40;
            SD_CLK = 1'b0;
        end
    endtask

    task automatic send6(input logic [47:0] c);
        logic [7:0] r;
        for (int k = 0; k < 6; k++) xfer(c[47-8*k -: 8], r);
    endtask

    initial begin
        logic [7:0] r;
        int         bad;
        int         nfe;

        // Reset state
        #23;
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_idle", 32'(oIdle), 32'd1);
        chk("rst_miso", 32'(SD_MISO), 32'd1);
        chk("rst_addr", oRdAddr, 32'd0);
        #20 Reset = 1'b1;
        #30 SD_CS = 1'b0;
        #100;

        // CMD0 -> NCR filler then R1 = 01
        send6(48'h40_00000000_95);
        xfer(8'hFF, r); chk("cmd0_ncr", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("cmd0_r1", 32'(r), 32'h01);
        chk("cmd0_idle", 32'(oIdle), 32'd1);

        // CMD41 -> R1 = 00, leaves idle
        send6(48'h69_00000000_FF);
        xfer(8'hFF, r); chk("cmd41_ncr", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("cmd41_r1", 32'(r), 32'h00);
        chk("cmd41_idle", 32'(oIdle), 32'd0);

        // CMD17 at 0x200 -> full block read
        send6(48'h51_00000200_FF);
        xfer(8'hFF, r); chk("rd_ncr", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("rd_r1", 32'(r), 32'h00);
        xfer(8'hFF, r); chk("rd_nac0", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("rd_nac1", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("rd_token", 32'(r), 32'hFE);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            xfer(8'hFF, r);
            if (r !== store_f(32'h200 + 32'(k))) bad++;
        end
        chk("rd_block_bad_bytes", 32'(bad), 32'd0);
        chk("rd_last_addr", oRdAddr, 32'h3FF);
        xfer(8'hFF, r); chk("rd_crc0", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("rd_crc1", 32'(r), 32'hFF);
        chk("rd_done_busy", 32'(oBusy), 32'd0);

        // Back to idle, then CMD17 while idle -> R1 = 01, no token
        send6(48'h40_00000000_95);
        xfer(8'hFF, r);
        xfer(8'hFF, r); chk("cmd0b_r1", 32'(r), 32'h01);
        send6(48'h51_00000000_FF);
        xfer(8'hFF, r);
        xfer(8'hFF, r); chk("rdidle_r1", 32'(r), 32'h01);
        nfe = 0;
        for (int k = 0; k < 16; k++) begin
            xfer(8'hFF, r);
            if (r === 8'hFE) nfe++;
        end
        chk("rdidle_no_token", 32'(nfe), 32'd0);
        chk("rdidle_busy", 32'(oBusy), 32'd0);

        // Unsupported command -> illegal-command bit plus idle
        send6(48'h45_00000000_FF);
        xfer(8'hFF, r);
        xfer(8'hFF, r); chk("cmd5_r1", 32'(r), 32'h05);

        // Non-command bytes in S_WAITCMD are ignored
        xfer(8'h3F, r); chk("junk3f_resp", 32'(r), 32'hFF);
        xfer(8'h80, r); chk("junk80_resp", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("junk_after", 32'(r), 32'hFF);
        chk("junk_busy", 32'(oBusy), 32'd0);
        chk("junk_idle", 32'(oIdle), 32'd1);

        // CMD41 then CMD17 at 0x1000, aborted by CS inside data byte 100
        send6(48'h69_00000000_FF);
        xfer(8'hFF, r);
        xfer(8'hFF, r); chk("cmd41b_r1", 32'(r), 32'h00);
        send6(48'h51_00001000_FF);
        for (int k = 0; k < 4; k++) xfer(8'hFF, r);
        xfer(8'hFF, r); chk("ab_token", 32'(r), 32'hFE);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            xfer(8'hFF, r);
            if (r !== store_f(32'h1000 + 32'(k))) bad++;
        end
        chk("ab_data_bad_bytes", 32'(bad), 32'd0);
        for (int i = 0; i < 4; i++) begin
            SD_MOSI = 1'b1;
            #40 SD_CLK = 1'b1;
            #40 SD_CLK = 1'b0;
        end
        #40 SD_CS = 1'b1;
        #1000;
        chk("ab_addr_frozen", oRdAddr, 32'h1065);
        chk("ab_busy", 32'(oBusy), 32'd0);
        chk("ab_idle_kept", 32'(oIdle), 32'd0);
        chk("ab_miso_high", 32'(SD_MISO), 32'd1);
        SD_CS = 1'b0;
        #100;
        send6(48'h40_00000000_95);
        xfer(8'hFF, r); chk("ab_cmd0_ncr", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("ab_cmd0_r1", 32'(r), 32'h01);

        // Reset in the middle of a command frame
        send6(48'h69_00000000_FF);
        xfer(8'hFF, r);
        xfer(8'hFF, r); chk("cmd41c_r1", 32'(r), 32'h00);
        xfer(8'h40, r);
        xfer(8'h00, r);
        chk("mid_cmd_busy", 32'(oBusy), 32'd1);
        #1 Reset = 1'b0;
        #2;
        chk("arst_busy", 32'(oBusy), 32'd0);
        chk("arst_idle", 32'(oIdle), 32'd1);
        chk("arst_miso", 32'(SD_MISO), 32'd1);
        chk("arst_addr", oRdAddr, 32'd0);
        #20 Reset = 1'b1;
        #100;
        send6(48'h40_00000000_95);
        xfer(8'hFF, r); chk("post_rst_ncr", 32'(r), 32'hFF);
        xfer(8'hFF, r); chk("post_rst_r1", 32'(r), 32'h01);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
